// File: rtl/counter_pkg.sv
// Shared state encoding and counter sizing helpers for the counter preload serializer.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LOAD     = 2'd3
    } state_e;

    localparam int COUNT_W       = 8;
    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_LOAD_HOLD = 1;

    // Bits needed to represent every value in 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 32'sd1);
    endfunction

    localparam int HALF_CNT_W = cnt_w(DEF_CLK_DIV);
    localparam int LOAD_CNT_W = cnt_w(DEF_LOAD_HOLD);

endpackage

// File: rtl/counter_load_serializer_sclk_tick_gen.sv
// Reloadable down-counter: tick is high once N cycles have elapsed since the last reload.
module sclk_tick_gen
    import counter_pkg::*;
#(
    parameter int N     = DEF_CLK_DIV,
    parameter int CNT_W = HALF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic tick
);

    logic [CNT_W-1:0] cnt_r;

    // Count down from N-1 after each reload and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (reload) begin
            cnt_r <= CNT_W'(N - 1);
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = (cnt_r == '0);

endmodule

// File: rtl/counter_load_serializer.sv
// Serializes a parallel preload value MSB-first onto sdi/sclk, then strobes load so the
// downstream counter commits it.
module counter_load_serializer
    import counter_pkg::*;
#(
    parameter int WIDTH     = COUNT_W,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int LOAD_HOLD = DEF_LOAD_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sdi_o,
    output logic             sclk_o,
    output logic             load_o,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W         = cnt_w(WIDTH);
    localparam int HALF_CNT_W_L  = cnt_w(CLK_DIV);
    localparam int LOAD_CNT_W_L  = cnt_w(LOAD_HOLD);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("counter_load_serializer: WIDTH must be >= 1");
        end
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("counter_load_serializer: CLK_DIV must be >= 1");
        end
        if (LOAD_HOLD < 1) begin : g_bad_load_hold
            $error("counter_load_serializer: LOAD_HOLD must be >= 1");
        end
    endgenerate

    state_e             state_r;
    state_e             state_nx_s;
    logic [WIDTH-1:0]   shreg_r;
    logic [WIDTH-1:0]   shreg_nx_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_nx_s;
    logic               done_nx_s;
    logic               half_tick_s;
    logic               load_tick_s;
    logic               half_reload_s;
    logic               load_reload_s;

    // Timers restart whenever their state is entered, including SHIFT_HI -> SHIFT_LO.
    assign half_reload_s = (state_nx_s != state_r) &&
                           ((state_nx_s == SHIFT_LO) || (state_nx_s == SHIFT_HI));
    assign load_reload_s = (state_nx_s != state_r) && (state_nx_s == LOAD);

    sclk_tick_gen #(
        .N     (CLK_DIV),
        .CNT_W (HALF_CNT_W_L)
    ) u_half_tick (
        .clk    (clk),
        .rst    (rst),
        .reload (half_reload_s),
        .tick   (half_tick_s)
    );

    sclk_tick_gen #(
        .N     (LOAD_HOLD),
        .CNT_W (LOAD_CNT_W_L)
    ) u_load_tick (
        .clk    (clk),
        .rst    (rst),
        .reload (load_reload_s),
        .tick   (load_tick_s)
    );

    // Next-state, shift-register and index update.
    always_comb begin
        state_nx_s = state_r;
        shreg_nx_s = shreg_r;
        idx_nx_s   = idx_r;
        done_nx_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_nx_s = SHIFT_LO;
                    shreg_nx_s = in_data;
                    idx_nx_s   = IDX_W'(WIDTH - 1);
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT_LO: begin
                if (half_tick_s) begin
                    state_nx_s = SHIFT_HI;
                end else begin
                    state_nx_s = SHIFT_LO;
                end
            end
            SHIFT_HI: begin
                if (half_tick_s && (idx_r != '0)) begin
                    state_nx_s = SHIFT_LO;
                    idx_nx_s   = idx_r - IDX_W'(1'b1);
                    shreg_nx_s = shreg_r << 1'b1;
                end else if (half_tick_s) begin
                    state_nx_s = LOAD;
                end else begin
                    state_nx_s = SHIFT_HI;
                end
            end
            LOAD: begin
                if (load_tick_s) begin
                    state_nx_s = IDLE;
                    done_nx_s  = 1'b1;
                end else begin
                    state_nx_s = LOAD;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, datapath and outputs; outputs are decoded from the next state so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            shreg_r  <= '0;
            idx_r    <= '0;
            in_ready <= 1'b1;
            sdi_o    <= 1'b0;
            sclk_o   <= 1'b0;
            load_o   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            shreg_r  <= shreg_nx_s;
            idx_r    <= idx_nx_s;
            in_ready <= (state_nx_s == IDLE);
            busy     <= (state_nx_s != IDLE);
            sclk_o   <= (state_nx_s == SHIFT_HI);
            load_o   <= (state_nx_s == LOAD);
            done     <= done_nx_s;
            // The MSB only moves on SHIFT_HI -> SHIFT_LO, i.e. on the sclk falling edge.
            sdi_o    <= ((state_nx_s == SHIFT_LO) || (state_nx_s == SHIFT_HI)) ?
                        shreg_nx_s[WIDTH-1] : 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_load_serializer.sv
// Scoreboard bench: three serializer configurations feeding a behavioural shift-register/counter model.
module tb_counter_load_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data_a [3];
    logic [2:0] in_valid_v = 3'b000;
    logic [2:0] in_ready_v, sdi_v, sclk_v, load_v, busy_v, done_v;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [7:0] exp_q [3][$];

    logic [7:0] sh_m [3]        = '{8'h00, 8'h00, 8'h00};
    int         hs_edge [3]     = '{0, 0, 0};
    int         edge_cnt [3]    = '{0, 0, 0};
    int         load_cnt [3]    = '{0, 0, 0};
    int         edges_total [3] = '{0, 0, 0};
    logic [2:0] sclk_p = 3'b000, sdi_p = 3'b000, load_p = 3'b000, done_p = 3'b000;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    counter_load_serializer #(.WIDTH(8), .CLK_DIV(2), .LOAD_HOLD(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data_a[0]), .in_valid(in_valid_v[0]),
        .in_ready(in_ready_v[0]), .sdi_o(sdi_v[0]), .sclk_o(sclk_v[0]),
        .load_o(load_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    counter_load_serializer #(.WIDTH(8), .CLK_DIV(1), .LOAD_HOLD(3)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data_a[1]), .in_valid(in_valid_v[1]),
        .in_ready(in_ready_v[1]), .sdi_o(sdi_v[1]), .sclk_o(sclk_v[1]),
        .load_o(load_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    counter_load_serializer #(.WIDTH(4), .CLK_DIV(3), .LOAD_HOLD(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data_a[2][3:0]), .in_valid(in_valid_v[2]),
        .in_ready(in_ready_v[2]), .sdi_o(sdi_v[2]), .sclk_o(sclk_v[2]),
        .load_o(load_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    function automatic int w_of(input int k);
        return (k == 2) ? 4 : 8;
    endfunction

    function automatic int d_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic int lh_of(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic logic [7:0] mask_of(input int k);
        return (k == 2) ? 8'h0F : 8'hFF;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, k, got, exp, $time);
        end
    endtask

    // Monitor: downstream shift register + counter model and per-frame timing checks.
    initial begin : monitor
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst) begin
                    if (done_v[k]) begin
                        chk("done_single_cycle", k, 32'(done_p[k]), 32'd0);
                        chk("done_cycle", k, cyc - hs_edge[k] + 1,
                            2 * w_of(k) * d_of(k) + lh_of(k) + 1);
                        chk("load_hold_len", k, load_cnt[k], lh_of(k));
                        chk("ready_at_done", k, 32'(in_ready_v[k]), 32'd1);
                    end
                    if (sdi_v[k] != sdi_p[k]) begin
                        chk("sdi_change_sclk_low", k, 32'(sclk_v[k]), 32'd0);
                    end
                    if (sclk_v[k] && !sclk_p[k]) begin
                        sh_m[k] = {sh_m[k][6:0], sdi_v[k]};
                        edge_cnt[k]++;
                        edges_total[k]++;
                    end
                    if (load_v[k]) begin
                        load_cnt[k]++;
                    end
                    if (load_v[k] && !load_p[k]) begin
                        chk("load_cycle", k, cyc - hs_edge[k] + 1, 2 * w_of(k) * d_of(k) + 1);
                        chk("sclk_rise_count", k, edge_cnt[k], w_of(k));
                        if (exp_q[k].size() == 0) begin
                            tests_run++;
                            tests_failed++;
                            $display("FAIL unexpected_load inst%0d: got a load strobe, expected none (t=%0t)",
                                     k, $time);
                        end else begin
                            chk("committed_value", k, 32'(sh_m[k] & mask_of(k)), 32'(exp_q[k].pop_front()));
                        end
                    end
                    if (in_valid_v[k] && in_ready_v[k]) begin
                        hs_edge[k]  = cyc + 1;
                        edge_cnt[k] = 0;
                        load_cnt[k] = 0;
                    end
                end
                sclk_p[k] = sclk_v[k];
                sdi_p[k]  = sdi_v[k];
                load_p[k] = load_v[k];
                done_p[k] = done_v[k];
            end
        end
    end

    task automatic check_rst(input int k);
        chk("rst_in_ready", k, 32'(in_ready_v[k]), 32'd1);
        chk("rst_sdi", k, 32'(sdi_v[k]), 32'd0);
        chk("rst_sclk", k, 32'(sclk_v[k]), 32'd0);
        chk("rst_load", k, 32'(load_v[k]), 32'd0);
        chk("rst_busy", k, 32'(busy_v[k]), 32'd0);
        chk("rst_done", k, 32'(done_v[k]), 32'd0);
    endtask

    // Called #1 after an edge with in_valid high; returns once a handshake edge has passed.
    task automatic wait_hs(input int k, output int n);
        logic hs;
        n = 0;
        do begin
            hs = in_ready_v[k];
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 200);
        if (!hs) begin
            tests_run++;
            tests_failed++;
            $display("FAIL hs_timeout inst%0d: got no handshake in %0d cycles, expected one", k, n);
        end
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done_v[k] && n < 500);
        if (!done_v[k]) begin
            tests_run++;
            tests_failed++;
            $display("FAIL done_timeout inst%0d: got no done in %0d cycles, expected one", k, n);
        end
    endtask

    task automatic send(input int k, input logic [7:0] d);
        int n;
        in_data_a[k]  = d;
        in_valid_v[k] = 1'b1;
        wait_hs(k, n);
        in_valid_v[k] = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        int e0;
        for (int k = 0; k < 3; k++) in_data_a[k] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_rst(k);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame.
        exp_q[0].push_back(8'hA5);
        send(0, 8'hA5);
        wait_done(0);

        // Back-to-back frames with in_valid held.
        repeat (2) @(posedge clk);
        #1;
        e0 = edges_total[0];
        exp_q[0].push_back(8'h01);
        exp_q[0].push_back(8'hFF);
        in_data_a[0]  = 8'h01;
        in_valid_v[0] = 1'b1;
        wait_hs(0, n);
        in_data_a[0]  = 8'hFF;
        wait_hs(0, n);
        chk("b2b_accept_cycle", 0, n, 34);
        in_valid_v[0] = 1'b0;
        wait_done(0);
        chk("b2b_sclk_rises", 0, edges_total[0] - e0, 16);

        // in_valid pulsed while busy is ignored.
        repeat (2) @(posedge clk);
        #1;
        exp_q[0].push_back(8'h5A);
        send(0, 8'h5A);
        repeat (9) @(posedge clk);
        #1;
        chk("busy_in_ready", 0, 32'(in_ready_v[0]), 32'd0);
        chk("busy_busy", 0, 32'(busy_v[0]), 32'd1);
        in_data_a[0]  = 8'h3C;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        wait_done(0);
        repeat (40) @(posedge clk);
        #1;

        // Reset in the middle of a frame; no commit for the abandoned value.
        send(0, 8'hC3);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_rst(0);
        repeat (40) @(posedge clk);
        #1;
        exp_q[0].push_back(8'h81);
        send(0, 8'h81);
        wait_done(0);

        // Minimum divider, long load hold.
        exp_q[1].push_back(8'h7E);
        send(1, 8'h7E);
        wait_done(1);

        // Narrow frame, slow divider.
        exp_q[2].push_back(8'h09);
        send(2, 8'h09);
        wait_done(2);

        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("queue_drained", k, exp_q[k].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
